// File: rtl/nic_pkg.sv
// Shared types and constants for the ring NIC node.
// Ring slot layout, packet types and queued transmit request.
package nic_pkg;

  localparam logic [5:0] BCAST_ID   = 6'd63;
  localparam logic [5:0] GSERVER_ID = 6'd62;

  typedef enum logic [2:0] {
    PT_READ,
    PT_AREAD,
    PT_WRITE,
    PT_ACK,
    PT_AACK,
    PT_ERR,
    PT_RETRY,
    PT_VPA
  } pkt_type_t;

  typedef struct packed {
    logic        v;
    logic [5:0]  sid;
    logic [5:0]  did;
    logic [5:0]  age;
    logic [3:0]  seq;
    pkt_type_t   typ;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } ring_pkt_t;

  typedef struct packed {
    logic [5:0]  did;
    pkt_type_t   typ;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } tx_req_t;

  typedef struct packed {
    logic       v;
    logic [5:0] sid;
    logic [3:0] seq;
  } seen_t;

  function automatic logic [5:0] age_inc(
    input logic [5:0] a
  );
    return (a == 6'h3f) ? a : a + 6'd1;
  endfunction

endpackage

// File: rtl/nic_txq.sv
// Transmit request FIFO for the ring node.
// Power-of-two depth, registered occupancy.
module nic_txq
  import nic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  tx_req_t                  data_i,
  input  logic                     pop_i,
  output tx_req_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  tx_req_t       mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == FULL);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign level_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/nic_ring_node.sv
// Ring NIC node: per-slot discard/consume/forward decision,
// local insertion from the transmit queue, broadcast de-dup.
module nic_ring_node
  import nic_pkg::*;
#(
  parameter int         TXQ_DEPTH  = 4,
  parameter int         SEEN_DEPTH = 8,
  parameter logic [5:0] MAX_AGE    = 6'd32,
  parameter int         CNT_W      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [5:0]                   id_i,
  input  ring_pkt_t                    pkt_i,
  output ring_pkt_t                    pkt_o,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  input  ring_pkt_t                    tx_pkt_i,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output ring_pkt_t                    rx_pkt_o,
  output logic [$clog2(TXQ_DEPTH):0]   txq_level_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);

  ring_pkt_t        pkt_q, pkt_d;
  ring_pkt_t        rx_pkt_q, rx_pkt_d;
  logic             rx_valid_q, rx_valid_d;
  logic [3:0]       seq_q, seq_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  seen_t            seen_q [SEEN_DEPTH];
  seen_t            seen_d [SEEN_DEPTH];

  tx_req_t          q_head, q_in;
  logic             q_full, q_empty, push, pop;

  logic is_b, own, aged, to_me, rx_free, seen_hit;
  logic c_empty, c_own, c_aged, c_take, c_fwd;
  logic slot_free, cap, record, drop_inc;

  // Only the request fields listed for local sends are carried.
  logic unused_tx;
  assign unused_tx = ^{tx_pkt_i.v, tx_pkt_i.sid,
                       tx_pkt_i.age, tx_pkt_i.seq,
                       tx_pkt_i.we};

  assign q_in = '{did: tx_pkt_i.did, typ: tx_pkt_i.typ,
                  sel: tx_pkt_i.sel, adr: tx_pkt_i.adr,
                  dat: tx_pkt_i.dat};

  assign tx_ready_o = !q_full;
  assign push       = tx_valid_i && tx_ready_o;

  nic_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (q_in),
    .pop_i   (pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .level_o (txq_level_o)
  );

  assign is_b    = (pkt_i.did == BCAST_ID);
  assign own     = (pkt_i.sid == id_i);
  assign aged    = (pkt_i.age >= MAX_AGE) && (pkt_i.did != id_i);
  assign to_me   = (pkt_i.did == id_i);
  assign rx_free = !rx_valid_q || rx_ready_i;

  always_comb begin
    seen_hit = 1'b0;
    for (int i = 0; i < SEEN_DEPTH; i++) begin
      if (seen_q[i].v && seen_q[i].sid == pkt_i.sid &&
          seen_q[i].seq == pkt_i.seq)
        seen_hit = 1'b1;
    end
  end

  assign c_empty = !pkt_i.v;
  assign c_own   = pkt_i.v && own;
  assign c_aged  = pkt_i.v && !own && aged;
  assign c_take  = pkt_i.v && !own && !aged && to_me && rx_free;
  assign c_fwd   = pkt_i.v && !own && !aged && !(to_me && rx_free);

  always_comb begin
    pkt_d     = '0;
    slot_free = 1'b1;
    cap       = 1'b0;
    record    = 1'b0;
    drop_inc  = 1'b0;
    pop       = 1'b0;
    unique case (1'b1)
      c_empty: ;
      c_own:   drop_inc = !is_b;
      c_aged:  drop_inc = 1'b1;
      c_take:  cap = 1'b1;
      c_fwd: begin
        pkt_d     = pkt_i;
        pkt_d.age = age_inc(pkt_i.age);
        slot_free = 1'b0;
        if (is_b && rx_free && !seen_hit) begin
          cap    = 1'b1;
          record = 1'b1;
        end
      end
      default: ;
    endcase
    if (slot_free && !q_empty) begin
      pop       = 1'b1;
      pkt_d     = '0;
      pkt_d.v   = 1'b1;
      pkt_d.sid = id_i;
      pkt_d.did = q_head.did;
      pkt_d.seq = seq_q;
      pkt_d.typ = q_head.typ;
      pkt_d.sel = q_head.sel;
      pkt_d.adr = q_head.adr;
      pkt_d.dat = q_head.dat;
    end
  end

  always_comb begin
    seq_d      = seq_q + {3'd0, pop};
    rx_valid_d = cap || (rx_valid_q && !rx_ready_i);
    rx_pkt_d   = cap ? pkt_i : rx_pkt_q;
    drop_d     = drop_q;
    if (drop_inc && drop_q != '1) drop_d = drop_q + 1'b1;
    for (int i = 0; i < SEEN_DEPTH; i++) seen_d[i] = seen_q[i];
    if (record) begin
      seen_d[0] = '{v: 1'b1, sid: pkt_i.sid, seq: pkt_i.seq};
      for (int i = 1; i < SEEN_DEPTH; i++) seen_d[i] = seen_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pkt_q      <= '0;
      rx_pkt_q   <= '0;
      rx_valid_q <= 1'b0;
      seq_q      <= '0;
      drop_q     <= '0;
      for (int i = 0; i < SEEN_DEPTH; i++) seen_q[i] <= '0;
    end else begin
      pkt_q      <= pkt_d;
      rx_pkt_q   <= rx_pkt_d;
      rx_valid_q <= rx_valid_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      for (int i = 0; i < SEEN_DEPTH; i++) seen_q[i] <= seen_d[i];
    end
  end

  assign pkt_o      = pkt_q;
  assign rx_pkt_o   = rx_pkt_q;
  assign rx_valid_o = rx_valid_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: doc/nic_ring_node.md
NIC_RING_NODE -- requirements
Module: nic_ring_node

Interface
REQ-001 SHALL have parameter TXQ_DEPTH, default 4, meaning transmit queue entries (power of two, at least 2).
REQ-002 SHALL have parameter SEEN_DEPTH, default 8, meaning broadcast de-duplication history entries (at least 1).
REQ-003 SHALL have parameter MAX_AGE, default 6'd32, meaning hop count at which a non-local packet is discarded.
REQ-004 SHALL have parameter CNT_W, default 16, meaning drop counter width.
REQ-005 SHALL use one clock, clk_i; reset is rst_ni, synchronous and active-low.
REQ-006 Ports, each given as name  direction  width  meaning:
- clk_i  in  1  clock
- rst_ni  in  1  sync active-low reset
- id_i  in  6  node id; 0, 62 and 63 are invalid
- pkt_i  in  ring_pkt_t  upstream ring slot
- pkt_o  out  ring_pkt_t  downstream ring slot, registered
- tx_valid_i  in  1  local request valid
- tx_ready_o  out  1  queue not full
- tx_pkt_i  in  ring_pkt_t  local request; did, typ, adr, sel, dat are used
- rx_valid_o  out  1  delivered packet valid
- rx_ready_i  in  1  local consumer ready
- rx_pkt_o  out  ring_pkt_t  delivered packet
- txq_level_o  out  $clog2(TXQ_DEPTH)+1  queue occupancy
- drop_cnt_o  out  CNT_W  saturating discard count

Function
REQ-007 The ring SHALL advance one hop per cycle: pkt_o is registered from the per-cycle slot decision on pkt_i.
REQ-008 A slot SHALL be treated as empty iff pkt_i.v==0; an empty slot forwarded as-is SHALL be all zeros.
REQ-009 Slot decisions SHALL use this priority per cycle: discard, then consume, then forward; insertion SHALL be evaluated only when the resulting slot is empty.
REQ-010 Discard SHALL apply when v=1 and one of these holds: (a) sid==id_i and did!=63, which is a unicast that returned undelivered; (b) sid==id_i and did==63, which is a broadcast completing its lap; (c) age>=MAX_AGE and did!=id_i. Case (b) SHALL NOT increment drop_cnt_o; cases (a) and (c) SHALL increment it, saturating at all-ones.
REQ-011 Unicast consume (did==id_i): if the rx register is free, or is being drained this cycle (rx_valid_o and rx_ready_i), the packet SHALL be latched into rx_pkt_o with rx_valid_o=1 next cycle and the slot emptied. Otherwise the packet SHALL be forwarded with age+1.
REQ-012 Broadcast (did==63, sid!=id_i) SHALL always be forwarded with age+1. It SHALL be latched into rx only if {sid,seq} is absent from the seen history and rx is free or draining. On latching, {sid,seq} SHALL be shifted into history entry 0 and the oldest entry discarded.
REQ-013 A broadcast refused because rx is busy SHALL NOT be recorded in the history, so it is captured on a later lap.
REQ-014 Forwarded packets SHALL have age incremented by 1, saturating at 63; all other fields SHALL be unchanged.
REQ-015 Insert: when the slot is empty and the queue is non-empty, the queue head SHALL be driven onto pkt_o with v=1, sid=id_i, age=0 and seq=seq_ctr; the head SHALL be popped and seq_ctr incremented (4-bit, wraps 15 to 0).
REQ-016 The queue SHALL push when tx_valid_i and tx_ready_o, with tx_ready_o = (level != TXQ_DEPTH).
REQ-017 Simultaneous push and pop SHALL leave the level unchanged.
REQ-018 A push into an empty queue SHALL be insertable no earlier than the next cycle (1-cycle minimum latency).
REQ-019 rx_valid_o/rx_pkt_o SHALL hold stable until rx_ready_i.
REQ-020 A new capture in the same cycle as a drain SHALL keep rx_valid_o=1 with the new packet.
REQ-021 txq_level_o and drop_cnt_o SHALL be registered.

Reset
REQ-022 When rst_ni=0 at a clk_i edge, all of the following SHALL be reset: pkt_o=0, rx_valid_o=0, rx_pkt_o=0, queue empty (txq_level_o=0, tx_ready_o=1), seen history entries invalid, seq_ctr=0, drop_cnt_o=0.
REQ-023 Reset mid-operation SHALL discard queued and in-flight local state without emitting partial packets.

Structure
REQ-024 nic_pkg SHALL hold ring_pkt_t {v, sid[5:0], did[5:0], age[5:0], seq[3:0], typ, we, sel[3:0], adr[31:0], dat[31:0]}, the pkt_type_t enum (PT_READ, PT_AREAD, PT_WRITE, PT_ACK, PT_AACK, PT_ERR, PT_RETRY, PT_VPA), and the constants BCAST_ID=63 and GSERVER_ID=62.
REQ-025 The transmit queue SHALL be a sub-module nic_txq (synchronous FIFO, parameter DEPTH, reports level).

Verification
REQ-026 id_i=5, pkt_i unicast did=5 while rx free -> rx_valid_o=1 next cycle with identical fields; pkt_o empty.
REQ-027 rx held busy (rx_ready_i=0), unicast did=5 arrives -> forwarded with age+1, drop_cnt_o unchanged.
REQ-028 Broadcast sid=3, seq=7 presented twice with rx free -> delivered once; both instances forwarded.
REQ-029 Push 4 packets with TXQ_DEPTH=4 and the ring full -> tx_ready_o=0, level=4; then 4 empty slots -> 4 inserts with seq 0..3 and level=0.
REQ-030 Packet did=9, age=MAX_AGE arriving at id 5 -> slot emptied, drop_cnt_o=1; own unicast returning (sid=5) -> drop_cnt_o=2.
REQ-031 Assert rst_ni=0 with 3 packets queued and rx valid -> next cycle level=0, rx_valid_o=0, pkt_o.v=0.
